// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among NUM_REQ hashing cores.
// gnt is combinational in the OWN cycle; rd_valid follows 1 cycle later; waiting cores hold req until granted.
module sha256_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rd_valid,
  output logic [31:0]             rd_data,
  output logic                    busy,
  output logic                    mem_clk,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] rd_owner_q, rd_owner_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;

  logic          access;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] owner_nxt;
  logic [7:0]    cnt_inc;

  assign access    = (state_q == OWN) && req[owner_q];
  assign owner_nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign cnt_inc   = cnt_q + 8'd1;

  // Scan downward so the requester closest above rr is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rd_pend_d  = access && !req_we[owner_q];
    rd_owner_d = access ? owner_q : rd_owner_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (access) begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = owner_nxt;
          end
        end else begin
          state_d = IDLE;
          rr_d    = owner_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Port fields are forced to zero whenever no core holds the grant.
  always_comb begin
    gnt            = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (access) begin
      gnt[owner_q]   = 1'b1;
      mem_we         = req_we[owner_q];
      mem_addr       = req_addr[16*owner_q +: 16];
      mem_write_data = req_wdata[32*owner_q +: 32];
    end
    rd_valid = '0;
    if (rd_pend_q) rd_valid[rd_owner_q] = 1'b1;
  end

  assign rd_data = mem_read_data;
  assign busy    = (state_q == OWN);
  assign mem_clk = clk;

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed bench: a default instance with a behavioural memory, plus a MAX_BURST=2 instance for rotation.
module tb_sha256_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [3:0]    req, req_we, gnt, rd_valid;
  logic [63:0]   req_addr;
  logic [127:0]  req_wdata;
  logic [31:0]   rd_data, mem_write_data, mem_read_data;
  logic          busy, mem_clk, mem_we;
  logic [15:0]   mem_addr;

  logic [3:0]    req2, req_we2, gnt2, rd_valid2;
  logic [63:0]   req_addr2;
  logic [127:0]  req_wdata2;
  logic [31:0]   rd_data2, mem_write_data2, mem_read_data2;
  logic          busy2, mem_clk2, mem_we2;
  logic [15:0]   mem_addr2;

  logic [31:0]   mem [0:65535];

  localparam logic [31:0] H [0:7] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  int n_assert = 0;
  int n_fail   = 0;
  int k, pk, j1, j2, m, oi;
  logic pg;
  logic [3:0] eg, erv, pg2, eg2;

  sha256_mem_arbiter #(.NUM_REQ(4), .MAX_BURST(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  sha256_mem_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .req_we(req_we2), .req_addr(req_addr2),
    .req_wdata(req_wdata2), .gnt(gnt2), .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2),
    .mem_clk(mem_clk2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_write_data(mem_write_data2),
    .mem_read_data(mem_read_data2)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA5000000 | 32'(i);
    reset_n = 1'b0;
    req = 4'b1111; req_we = 4'b1111; req_addr = {4{16'h1234}}; req_wdata = {4{32'hCAFEF00D}};
    req2 = 4'b0000; req_we2 = 4'b0100; req_wdata2 = '0; mem_read_data2 = '0;
    for (int r = 0; r < 4; r++) begin
      req_addr2[16*r +: 16]  = 16'h0200 + 16'(r);
      req_wdata2[32*r +: 32] = 32'h11110000 + 32'(r);
    end

    // Reset holds outputs at zero even with all cores requesting across edges.
    #1;
    chk("rst_gnt", gnt, 0);
    cyc(); cyc(); #5;
    chk("rst_gnt_hold", gnt, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_write_data, 0);
    chk("rst_gnt2", gnt2, 0);
    chk("mem_clk", mem_clk, clk);
    cyc();
    req = 4'b0000; req_we = 4'b0000;
    reset_n = 1'b1;

    // Single core 0 reads 20 words: 16-access burst, forced release, then 4 more.
    k = 0; pk = 0; pg = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      req = (c < 22) ? 4'b0001 : 4'b0000;
      req_we = 4'b0000;
      req_addr[15:0] = 16'(k);
      #5;
      eg = ((c >= 1 && c <= 16) || (c >= 18 && c <= 21)) ? 4'b0001 : 4'b0000;
      chk("t1_gnt", gnt, eg);
      chk("t1_busy", busy, ((c >= 1 && c <= 16) || (c >= 18 && c <= 22)) ? 1 : 0);
      chk("t1_rdv", rd_valid, pg ? 4'b0001 : 4'b0000);
      if (pg) chk("t1_rdata", rd_data, 32'hA5000000 | 32'(pk));
      if (eg != 0) chk("t1_addr", mem_addr, k);
      else         chk("t1_idle_addr", mem_addr, 0);
      pg = (eg != 0); pk = k;
      if (eg != 0) k++;
    end

    // MAX_BURST=2 rotation with all four cores requesting; core 2 writes, the rest read.
    pg2 = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      cyc();
      req2 = 4'b1111;
      mem_read_data2 = 32'hD0000000 | 32'(c);
      #5;
      oi  = (c / 3) % 4;
      eg2 = (c % 3 == 0) ? 4'b0000 : 4'(1 << oi);
      chk("t2_gnt", gnt2, eg2);
      chk("t2_onehot", $onehot0(gnt2), 1);
      chk("t2_rdv", rd_valid2, pg2 & 4'b1011);
      chk("t2_rdata", rd_data2, 32'hD0000000 | 32'(c));
      chk("t2_busy", busy2, (eg2 != 0) ? 1 : 0);
      if (eg2 != 0) begin
        chk("t2_addr", mem_addr2, 32'h0200 + 32'(oi));
        chk("t2_we", mem_we2, (oi == 2) ? 1 : 0);
        chk("t2_wdata", mem_write_data2, 32'h11110000 + 32'(oi));
      end else begin
        chk("t2_idle_addr", mem_addr2, 0);
        chk("t2_idle_we", mem_we2, 0);
      end
      pg2 = eg2;
    end
    req2 = 4'b0000;
    chk("mem_clk2", mem_clk2, clk);

    // Core 2 writes H0..H7 while core 1 waits, then core 1 reads them back.
    j1 = 0; j2 = 0;
    for (int d = 0; d < 21; d++) begin
      cyc();
      req = {1'b0, (d <= 8), (d >= 1 && d <= 18), 1'b0};
      req_we = 4'b0100;
      req_addr[47:32]  = 16'h0100 + 16'(j2);
      req_wdata[95:64] = (j2 < 8) ? H[j2] : 32'h0;
      req_addr[31:16]  = 16'h0100 + 16'(j1);
      #5;
      eg  = (d >= 1 && d <= 8) ? 4'b0100 : (d >= 11 && d <= 18) ? 4'b0010 : 4'b0000;
      erv = (d >= 12 && d <= 19) ? 4'b0010 : 4'b0000;
      chk("t3_gnt", gnt, eg);
      chk("t3_rdv", rd_valid, erv);
      if (erv != 0) chk("t3_readback", rd_data, H[d-12]);
      if (d >= 1 && d <= 8) begin
        chk("t3_we", mem_we, 1);
        chk("t3_waddr", mem_addr, 32'h0100 + 32'(j2));
        chk("t3_wdata", mem_write_data, H[j2]);
        j2++;
      end
      if (d >= 11 && d <= 18) begin
        chk("t3_rd_we", mem_we, 0);
        chk("t3_raddr", mem_addr, 32'h0100 + 32'(j1));
        j1++;
      end
      if (d == 9)  chk("t3_release_busy", busy, 1);
      if (d == 10) chk("t3_idle_busy", busy, 0);
    end

    // Reset pulsed during a core 1 read burst; rr is 2 beforehand.
    j1 = 0;
    for (int f = 0; f < 4; f++) begin
      cyc();
      req = 4'b0010; req_we = 4'b0000;
      req_addr[31:16] = 16'h0010 + 16'(j1);
      #5;
      chk("t5_gnt", gnt, (f >= 1) ? 4'b0010 : 4'b0000);
      chk("t5_rdv", rd_valid, (f >= 2) ? 4'b0010 : 4'b0000);
      if (f >= 2) chk("t5_rdata", rd_data, 32'hA5000010 + 32'(f - 2));
      if (f >= 1) j1++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_rdv", rd_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", mem_addr, 0);
    cyc();
    chk("t5_rst_rdv_hold", rd_valid, 0);
    reset_n = 1'b1;
    req = 4'b1010; req_we = 4'b1000;
    req_addr[31:16] = 16'h0020;
    req_addr[63:48] = 16'h0180; req_wdata[127:96] = 32'hC3000000;
    #5;
    chk("t5_post_gnt", gnt, 0);
    chk("t5_post_rdv", rd_valid, 0);
    chk("t5_post_busy", busy, 0);
    cyc(); #5;
    chk("t5_win_gnt", gnt, 4'b0010);
    chk("t5_win_addr", mem_addr, 32'h0020);
    cyc();
    req = 4'b1000;
    #5;
    chk("t5_drop_gnt", gnt, 0);
    chk("t5_drop_rdv", rd_valid, 4'b0010);
    chk("t5_drop_rdata", rd_data, 32'hA5000020);
    cyc(); #5;
    chk("t5_idle_busy", busy, 0);

    // Core 3 drops after 3 writes with core 0 waiting; core 0 reads one written word back.
    m = 0;
    for (int e = 0; e < 8; e++) begin
      cyc();
      req = {(e <= 2), 1'b0, 1'b0, (e <= 5)};
      req_we = 4'b1000;
      req_addr[63:48]   = 16'h0180 + 16'(m);
      req_wdata[127:96] = 32'hC3000000 + 32'(m);
      req_addr[15:0]    = 16'h0181;
      #5;
      eg = (e <= 2) ? 4'b1000 : (e == 5) ? 4'b0001 : 4'b0000;
      chk("t4_gnt", gnt, eg);
      chk("t4_busy", busy, (e <= 3 || e == 5 || e == 6) ? 1 : 0);
      chk("t4_rdv", rd_valid, (e == 6) ? 4'b0001 : 4'b0000);
      if (e <= 2) begin
        chk("t4_we", mem_we, 1);
        chk("t4_waddr", mem_addr, 32'h0180 + 32'(m));
        chk("t4_wdata", mem_write_data, 32'hC3000000 + 32'(m));
        m++;
      end
      if (e == 3) begin
        chk("t4_release_we", mem_we, 0);
        chk("t4_release_addr", mem_addr, 0);
        chk("t4_release_wdata", mem_write_data, 0);
      end
      if (e == 5) chk("t4_c0_addr", mem_addr, 32'h0181);
      if (e == 6) chk("t4_c0_rdata", rd_data, 32'hC3000001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_mem_arbiter.md
# sha256_mem_arbiter

Round-robin arbiter that shares the single word-addressed testbench memory port (16-bit address, 32-bit data, synchronous read) among NUM_REQ SHA-256 hashing cores. It sits between the parallel cores and the memory. Each core keeps the same memory handshake it would use standalone; the only addition is a request/grant pair. An owning core is granted bursts of up to MAX_BURST consecutive accesses, which lets it stream message words or write back H0..H7 without interruption.

## Interface
- NUM_REQ, 4: number of requesting cores; legal range 2..8.
- MAX_BURST, 16: maximum accesses per ownership period; legal range 1..255.

- clk  in  1  single clock; mem_clk is driven from it.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-core access request; held high while the core has accesses pending.
- req_we  in  NUM_REQ  per-core write enable for the current access.
- req_addr  in  16*NUM_REQ  core r uses bits [16r+15:16r].
- req_wdata  in  32*NUM_REQ  core r uses bits [32r+31:32r].
- gnt  out  NUM_REQ  one-hot; the current-cycle access of that core is issued to memory.
- rd_valid  out  NUM_REQ  one-hot; rd_data holds that core's read result this cycle.
- rd_data  out  32  equals mem_read_data.
- busy  out  1  high while a core owns the port.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory word address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data; valid one cycle after the address edge.

## Operation
- Registered state: state (IDLE/OWN), owner index, round-robin pointer rr, burst counter cnt (8 bit), rd_pend, rd_owner.
- IDLE
  - If any req is high: owner ← the first requester at or above rr, searching upward modulo NUM_REQ; cnt ← 0; go to OWN.
  - No access is issued in IDLE.
- OWN, access cycle: while req[owner]=1, gnt[owner]=1 combinationally. In that cycle:
  - mem_addr = req_addr[owner]
  - mem_we = req_we[owner]
  - mem_write_data = req_wdata[owner]
  - cnt increments
- OWN → IDLE, with rr ← (owner+1) mod NUM_REQ, when either:
  - req[owner]=0 in a cycle; no access is issued that cycle; or
  - an access makes cnt equal MAX_BURST; that access is still issued.
- Read return: a granted access with req_we=0 sets rd_pend=1 and rd_owner=owner. In the next cycle rd_valid[rd_owner]=1 and rd_data=mem_read_data. This happens regardless of state or owner, so the last read of a burst is still returned after release.
- Idle port: when no gnt is asserted, mem_we=0, mem_addr=0 and mem_write_data=0.
- Fairness: a requester waits at most (NUM_REQ−1)×(MAX_BURST+1) cycles after IDLE arbitration, beyond the current owner's remaining burst.
- Simultaneous events:
  - A new req arriving during OWN waits; it does not pre-empt the owner.
  - A releasing owner that reasserts req in the next IDLE cycle competes normally, and it has the lowest priority because rr has moved past it.
- Misuse: req_we, req_addr and req_wdata of non-granted cores are ignored. A core must hold its access fields stable until it sees gnt.

## Timing
- Reset, asynchronous: state=IDLE, owner=0, rr=0, cnt=0, rd_pend=0. Outputs:
  - gnt=0, rd_valid=0, busy=0
  - mem_we=0, mem_addr=0, mem_write_data=0
- Arbitration latency: first gnt comes 1 cycle after req rises with the port free.
- Read latency: rd_valid comes 1 cycle after the gnt of the read.
- Write: committed at the clock edge that ends the gnt cycle.
- Burst throughput: 1 access per cycle. Each ownership period costs 1 IDLE cycle, plus 1 release cycle when the owner drops req.
- Reset mid-burst: the access in flight is abandoned and a pending rd_valid is not produced. After reset, arbitration restarts at requester 0.

## Test plan
- Single core 0 reads addresses 0x0000..0x0013 (20 words) with MAX_BURST=16:
  - 16 gnts follow 1 IDLE cycle, then a forced release, 1 IDLE cycle, and 4 more gnts.
  - Each rd_valid[0] appears 1 cycle after its gnt, with rd_data equal to the memory contents.
- All 4 cores request continuously with 2-access bursts:
  - Grant order is 0,0,1,1,2,2,3,3,0…, with one IDLE cycle between owners.
  - No gnt is ever non-one-hot.
- Core 2 writes 8 words (H0..H7 = 0x6a09e667…0x5be0cd19) to 0x0100..0x0107 while core 1 requests:
  - The writes complete uninterrupted.
  - A read-back by core 1 returns the same values.
- Core 3 drops req after 3 of its MAX_BURST accesses, with core 0 waiting:
  - Release cycle shows gnt=0 and mem_we=0.
  - rr becomes 0 and core 0 is granted 2 cycles after the drop.
- reset_n is pulsed low during a core 1 read burst:
  - Outputs are immediately zero and no rd_valid follows.
  - After release with req=4'b1010, core 1 wins because the search starts at rr=0.
- The last access of a burst is a read:
  - rd_valid for the old owner is asserted during the IDLE cycle after release.
  - It does not collide with the new owner's first rd_valid.
